pipeline_run_controller: RTL and testbench
==========================================

// Module: pipeline_run_controller
// PURPOSE
//  Sequences the 5-stage MIPS datapath for bring-up: loads program words into instruction memory,
//  then runs free or single-steps it via a clock enable. Stops on a HALT word at fetch and drains
//  the in-flight instructions before reporting done. Sits between the host command port and
//  Datapath1 / instruction memory.
// PARAMETERS
//  IMEM_ADDR_W   8            width of instruction address / fetch PC
//  DRAIN_CYCLES  4            enabled cycles after HALT so in-flight instrs retire (stages-1)
//  HALT_WORD     32'hFFFFFFFF fetch_instr value that ends a run
//  WDT_LIMIT     1024         max RUN cycles before abort (used only with RUN_CTRL_WATCHDOG_EN)
// PORTS
//  clock        in   1            single clock for the block
//  resetGral    in   1            synchronous, active-high reset
//  cmd_valid    in   1            host command valid
//  cmd_ready    out  1            command accepted when cmd_valid & cmd_ready
//  cmd_op       in   2            00 LOAD, 01 RUN, 10 STEP, 11 HALT
//  cmd_data     in   32           instruction word for LOAD
//  imem_we      out  1            instruction-memory write strobe
//  imem_addr    out  IMEM_ADDR_W  write address (load pointer)
//  imem_wdata   out  32           write data
//  dp_reset     out  1            datapath reset (ORed with resetGral at top level)
//  dp_enable    out  1            datapath clock enable
//  dp_flush_if  out  1            IF stage substitutes NOP for the fetched word
//  fetch_pc     in   IMEM_ADDR_W  datapath fetchOut
//  fetch_instr  in   32           word currently at fetch
//  busy         out  1            state != IDLE
//  done         out  1            one-cycle pulse: run/step finished
//  wdt_err      out  1            sticky watchdog abort flag (0 if macro off)
// BEHAVIOUR
//  - Reset: state IDLE, load ptr 0, primed 0; imem_we, dp_reset, dp_enable, dp_flush_if, busy,
//    done, wdt_err all 0; imem_addr 0, imem_wdata 0. Reset mid-run aborts with no done pulse.
//  - States: IDLE, PRIME, RUN, STEP, DRAIN. Outputs registered; one-cycle latency from accept.
//  - cmd_ready = 1 in IDLE and RUN; 0 in PRIME, STEP, DRAIN. In RUN only HALT acts; other ops
//    are accepted and dropped.
//  - IDLE+LOAD: next cycle imem_we=1, imem_addr=ptr, imem_wdata=cmd_data; ptr+1, wraps
//    2^IMEM_ADDR_W-1 -> 0; primed cleared. Back-to-back LOADs write every cycle.
//  - IDLE+RUN/STEP with primed=0: PRIME for 1 cycle (dp_reset=1, dp_enable=0), set primed,
//    ptr=0, then RUN/STEP. With primed=1: go directly.
//  - IDLE+HALT: no-op.
//  - RUN: dp_enable=1 each cycle. fetch_instr==HALT_WORD, or HALT cmd accepted -> DRAIN.
//    If both occur in the same cycle, a single DRAIN is entered.
//  - DRAIN: dp_enable=1, dp_flush_if=1 for exactly DRAIN_CYCLES cycles, then IDLE, done=1.
//  - STEP: dp_enable=1 for exactly one cycle, then IDLE, done=1. A HALT_WORD at fetch in STEP
//    goes to DRAIN instead.
//  - The PC is not rewound after a run; a further RUN continues from fetch_pc. LOAD forces
//    re-prime.
// CONFIGURATION
//  RUN_CTRL_WATCHDOG_EN defined: counter of RUN cycles. On reaching WDT_LIMIT: wdt_err<=1
//    (sticky until reset), state -> IDLE immediately, dp_enable=0, no drain, no done.
//  Undefined: no counter; wdt_err tied 0; RUN unbounded.
// STRUCTURE
//  Package run_ctrl_pkg: state encoding, CMD_LOAD/RUN/STEP/HALT codes, default HALT_WORD.
//  Sub-module run_ctrl_watchdog (counter + compare), instantiated only under the macro.
//  Drain counter and load pointer stay inline.
// TESTING
//  1 LOAD x3 (0x20400282, 0x20410003, 0xFFFFFFFF) -> imem_we pulses at addrs 0,1,2 with those words.
//  2 RUN after load -> dp_reset 1 cycle, dp_enable; HALT at pc 2 -> 4 flush cycles, done 1 cycle.
//  3 STEP x2 from primed IDLE -> exactly one dp_enable cycle + done each; cmd_ready 0 meanwhile.
//  4 HALT cmd in RUN on same cycle as HALT_WORD -> single 4-cycle DRAIN, one done.
//  5 256 LOADs with IMEM_ADDR_W=8 -> addr 255 then 0 (wrap); resetGral in DRAIN -> all outs 0.
//  6 Macro on, WDT_LIMIT=16, no HALT word -> after 16 RUN cycles wdt_err=1, IDLE, done stays 0.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : run_ctrl_pkg
// Description : Shared state encoding, host command codes and default HALT
//               word for the pipeline run controller.
// Revision    : 1.0 - initial release
// ============================================================================
package run_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRIME = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_STEP  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam logic [1:0] CMD_LOAD = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_HALT = 2'b11;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    // States in which the datapath clock enable is asserted
    function automatic logic state_enables_dp(input logic [2:0] st);
        return (st == ST_RUN) || (st == ST_STEP) || (st == ST_DRAIN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/run_ctrl_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : run_ctrl_watchdog
// Description : Counts consecutive RUN cycles and flags the cycle on which
//               the LIMIT-th one occurs.
// Revision    : 1.0 - initial release
// ============================================================================
module run_ctrl_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_expire
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(LIMIT - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign o_expire = i_run && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/pipeline_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_run_controller
// Description : Loads instruction memory from the host port, then runs or
//               single-steps the 5-stage datapath and drains it on HALT.
//               Optional watchdog abort: define RUN_CTRL_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_run_controller
    import run_ctrl_pkg::*;
#(
    parameter int unsigned IMEM_ADDR_W  = 8,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter logic [31:0] HALT_WORD    = HALT_WORD_DEFAULT,
    parameter int unsigned WDT_LIMIT    = 1024
) (
    input  logic                   clock,
    input  logic                   resetGral,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [31:0]            cmd_data,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            imem_wdata,
    output logic                   dp_reset,
    output logic                   dp_enable,
    output logic                   dp_flush_if,
    input  logic [IMEM_ADDR_W-1:0] fetch_pc,
    input  logic [31:0]            fetch_instr,
    output logic                   busy,
    output logic                   done,
    output logic                   wdt_err
);

    localparam int unsigned DRN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRN_W-1:0]       c_DRAIN_LAST = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [DRN_W-1:0]       c_DRN_ONE    = DRN_W'(1);
    localparam logic [IMEM_ADDR_W-1:0] c_PTR_ONE    = IMEM_ADDR_W'(1);

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [IMEM_ADDR_W-1:0] r_ptr;
    logic                   r_primed;
    logic                   r_prime_to_step;
    logic [DRN_W-1:0]       r_drain_cnt;
    logic                   r_imem_we;
    logic [IMEM_ADDR_W-1:0] r_imem_addr;
    logic [31:0]            r_imem_wdata;
    logic                   r_dp_reset;
    logic                   r_dp_enable;
    logic                   r_dp_flush_if;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_accept;
    logic                   w_halt_fetch;
    logic                   w_wdt_expire;
    logic                   w_unused_ok;

    // The PC is owned by the datapath; it is observed only through fetch_instr
    assign w_unused_ok  = &{1'b0, fetch_pc};

    assign cmd_ready    = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign w_accept     = cmd_valid && cmd_ready;
    assign w_halt_fetch = (fetch_instr == HALT_WORD);

`ifdef RUN_CTRL_WATCHDOG_EN
    logic r_wdt_err;

    run_ctrl_watchdog #(
        .LIMIT (WDT_LIMIT)
    ) u_watchdog (
        .clk      (clock),
        .rst      (resetGral),
        .i_run    (r_state == ST_RUN),
        .o_expire (w_wdt_expire)
    );

    always_ff @(posedge clock) begin
        if (resetGral) begin
            r_wdt_err <= 1'b0;
        end else if (w_wdt_expire) begin
            r_wdt_err <= 1'b1;
        end
    end

    assign wdt_err = r_wdt_err;
`else
    assign w_wdt_expire = 1'b0;
    assign wdt_err      = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (cmd_op == CMD_RUN)) begin
                    w_state_nxt = r_primed ? ST_RUN : ST_PRIME;
                end else if (w_accept && (cmd_op == CMD_STEP)) begin
                    w_state_nxt = r_primed ? ST_STEP : ST_PRIME;
                end
            end
            ST_PRIME: w_state_nxt = r_prime_to_step ? ST_STEP : ST_RUN;
            ST_RUN: begin
                // Watchdog abort wins over a simultaneous halt: no drain, no done
                if (w_wdt_expire) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_halt_fetch || (w_accept && (cmd_op == CMD_HALT))) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_STEP:  w_state_nxt = w_halt_fetch ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: w_state_nxt = (r_drain_cnt == c_DRAIN_LAST) ? ST_IDLE : ST_DRAIN;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (resetGral) begin
            r_state         <= ST_IDLE;
            r_ptr           <= '0;
            r_primed        <= 1'b0;
            r_prime_to_step <= 1'b0;
            r_drain_cnt     <= '0;
            r_imem_we       <= 1'b0;
            r_imem_addr     <= '0;
            r_imem_wdata    <= '0;
            r_dp_reset      <= 1'b0;
            r_dp_enable     <= 1'b0;
            r_dp_flush_if   <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_imem_we <= 1'b0;
            if ((r_state == ST_IDLE) && w_accept && (cmd_op == CMD_LOAD)) begin
                r_imem_we    <= 1'b1;
                r_imem_addr  <= r_ptr;
                r_imem_wdata <= cmd_data;
                r_ptr        <= r_ptr + c_PTR_ONE;
                r_primed     <= 1'b0;
            end
            if ((r_state == ST_IDLE) && w_accept) begin
                r_prime_to_step <= (cmd_op == CMD_STEP);
            end
            if (r_state == ST_PRIME) begin
                r_primed <= 1'b1;
                r_ptr    <= '0;
            end
            r_drain_cnt <= (r_state == ST_DRAIN) ? (r_drain_cnt + c_DRN_ONE) : '0;

            // Outputs follow the state being entered, giving one-cycle latency
            r_dp_reset    <= (w_state_nxt == ST_PRIME);
            r_dp_enable   <= state_enables_dp(w_state_nxt);
            r_dp_flush_if <= (w_state_nxt == ST_DRAIN);
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_done        <= (w_state_nxt == ST_IDLE) &&
                             ((r_state == ST_STEP) || (r_state == ST_DRAIN));
        end
    end

    assign imem_we     = r_imem_we;
    assign imem_addr   = r_imem_addr;
    assign imem_wdata  = r_imem_wdata;
    assign dp_reset    = r_dp_reset;
    assign dp_enable   = r_dp_enable;
    assign dp_flush_if = r_dp_flush_if;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_run_controller
// Description : Scoreboard bench with a stub datapath (PC + imem) and a
//               program-level reference model of load/run/step/drain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_run_controller;
    import run_ctrl_pkg::*;

    localparam int          AW  = 8;
    localparam int          DRN = 4;
    localparam int          WDT = 16;
    localparam logic [31:0] HW  = 32'hFFFF_FFFF;

    logic          clock, resetGral, cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [31:0]   cmd_data, imem_wdata, fetch_instr;
    logic          imem_we, dp_reset, dp_enable, dp_flush_if, busy, done, wdt_err;
    logic [AW-1:0] imem_addr, fetch_pc;

    pipeline_run_controller #(
        .IMEM_ADDR_W (AW),
        .DRAIN_CYCLES(DRN),
        .HALT_WORD   (HW),
        .WDT_LIMIT   (WDT)
    ) dut (
        .clock(clock), .resetGral(resetGral), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .dp_reset(dp_reset), .dp_enable(dp_enable),
        .dp_flush_if(dp_flush_if), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
        .busy(busy), .done(done), .wdt_err(wdt_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stub datapath: PC advances on enable, instruction memory written by the DUT
    logic [31:0]   stub_mem [256];
    logic [AW-1:0] stub_pc;
    always @(posedge clock) begin
        if (resetGral || dp_reset) stub_pc <= '0;
        else if (dp_enable)        stub_pc <= stub_pc + 8'd1;
        if (imem_we) stub_mem[imem_addr] <= imem_wdata;
    end
    assign fetch_pc    = stub_pc;
    assign fetch_instr = stub_mem[stub_pc];

    typedef struct {
        bit          is_done;
        logic [7:0]  addr;
        logic [31:0] data;
        int          en;
        int          fl;
        int          rs;
    } exp_t;
    exp_t q[$];

    int vectors = 0;
    int miscompares = 0;
    int en_cnt = 0, fl_cnt = 0, rs_cnt = 0;
    bit in_step = 0;

    // Reference model state
    logic [31:0] m_mem [256];
    int m_ptr, m_pc, gap_cnt;
    bit m_primed;

    function automatic void chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_evt(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got unexpected event expected none at %0t", name, $time);
    endfunction

    // Monitor / scoreboard
    always @(negedge clock) begin
        if (resetGral) begin
            en_cnt = 0; fl_cnt = 0; rs_cnt = 0;
        end else begin
            en_cnt += int'(dp_enable);
            fl_cnt += int'(dp_flush_if);
            rs_cnt += int'(dp_reset);
            if (dp_reset || dp_flush_if) chk("ready_low_prime_drain", cmd_ready, 0);
            if (in_step && dp_enable && !dp_flush_if) chk("ready_low_step", cmd_ready, 0);
            if (imem_we) begin
                if (q.size() == 0 || q[0].is_done) fail_evt("imem_write");
                else begin
                    chk("imem_addr", imem_addr, q[0].addr);
                    chk("imem_wdata", imem_wdata, q[0].data);
                    void'(q.pop_front());
                end
            end
            if (done) begin
                if (q.size() == 0 || !q[0].is_done) fail_evt("done_pulse");
                else begin
                    chk("done_enable_cycles", en_cnt, q[0].en);
                    chk("done_flush_cycles", fl_cnt, q[0].fl);
                    chk("done_reset_cycles", rs_cnt, q[0].rs);
                    chk("done_busy", busy, 0);
                    void'(q.pop_front());
                end
                en_cnt = 0; fl_cnt = 0; rs_cnt = 0;
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] d);
        cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clock);
            if (cmd_ready) break;
            if (t > 100) begin fail_evt("send_timeout"); break; end
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = $urandom;
    endtask

    task automatic wait_idle();
        for (int t = 0; ; t++) begin
            @(negedge clock);
            if (!busy) break;
            if (t > 300) begin fail_evt("idle_timeout"); break; end
        end
        @(posedge clock); #1;
    endtask

    function automatic int dist_to_halt(input int p);
        for (int i = 0; i < 256; i++) if (m_mem[(p + i) % 256] == HW) return i + 1;
        return 1000;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        if ($urandom_range(0, 4) == 0 || gap_cnt >= 6) begin
            w = HW; gap_cnt = 0;
        end else begin
            w = $urandom & 32'hFFFF_FFFE; gap_cnt++;
        end
        return w;
    endfunction

    task automatic load_word(input logic [31:0] w);
        q.push_back('{is_done: 1'b0, addr: 8'(m_ptr), data: w, en: 0, fl: 0, rs: 0});
        m_mem[m_ptr] = w;
        m_ptr = (m_ptr + 1) % 256;
        m_primed = 0;
        send(CMD_LOAD, w);
    endtask

    // kh > 0: host HALT accepted on the kh-th RUN cycle (if the run lasts that long)
    task automatic do_run(input int kh);
        bit pr;
        int l, r, d;
        pr = !m_primed;
        if (pr) begin m_pc = 0; m_ptr = 0; m_primed = 1; end
        l = dist_to_halt(m_pc);
        r = (kh > 0 && kh < l) ? kh : l;
        q.push_back('{is_done: 1'b1, addr: 8'd0, data: 32'd0, en: r + DRN, fl: DRN, rs: int'(pr)});
        m_pc = (m_pc + r + DRN) % 256;
        send(CMD_RUN, $urandom);
        if (kh > 0) begin
            d = pr ? kh : kh - 1;
            if (d > 0) begin repeat (d) @(posedge clock); #1; end
            send(CMD_HALT, $urandom);
        end
        wait_idle();
        chk("idle_ready", cmd_ready, 1);
    endtask

    task automatic do_step();
        bit pr;
        int e;
        pr = !m_primed;
        if (pr) begin m_pc = 0; m_ptr = 0; m_primed = 1; end
        e = (m_mem[m_pc] == HW) ? 1 + DRN : 1;
        q.push_back('{is_done: 1'b1, addr: 8'd0, data: 32'd0, en: e,
                      fl: (e > 1) ? DRN : 0, rs: int'(pr)});
        m_pc = (m_pc + e) % 256;
        in_step = 1;
        send(CMD_STEP, $urandom);
        wait_idle();
        in_step = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_imem_we"}, imem_we, 0);
        chk({tag, "_imem_addr"}, imem_addr, 0);
        chk({tag, "_imem_wdata"}, imem_wdata, 0);
        chk({tag, "_dp_reset"}, dp_reset, 0);
        chk({tag, "_dp_enable"}, dp_enable, 0);
        chk({tag, "_dp_flush_if"}, dp_flush_if, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_wdt_err"}, wdt_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, sel;
        for (int i = 0; i < 256; i++) begin
            stub_mem[i] = (i % 8 == 5) ? HW : 32'h0;
            m_mem[i]    = (i % 8 == 5) ? HW : 32'h0;
        end
        m_ptr = 0; m_pc = 0; m_primed = 0; gap_cnt = 0;
        resetGral = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 32'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        chk("reset_ready", cmd_ready, 1);
        @(posedge clock); #1;
        resetGral = 1'b0;

        // Directed program: two instructions then HALT at address 2
        load_word(32'h2040_0282);
        load_word(32'h2041_0003);
        load_word(HW);
        do_run(0);
        do_step();
        do_step();
        // Host HALT lands on the same cycle the HALT word reaches fetch
        do_run(dist_to_halt(m_pc));

        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 2) begin
                n = $urandom_range(1, 6);
                for (int k = 0; k < n - 1; k++) load_word(rand_word());
                load_word(HW);
                gap_cnt = 0;
            end else if (sel <= 5) begin
                do_run(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 10));
            end else if (sel <= 7) begin
                do_step();
            end else if (sel == 8) begin
                send(CMD_HALT, $urandom);
                @(negedge clock);
                chk("idle_halt_busy", busy, 0);
                @(posedge clock); #1;
            end else begin
                do_run(0);
            end
        end

        // Full wrap of the load pointer
        for (int k = 0; k < 255; k++) load_word(rand_word());
        load_word(HW);
        gap_cnt = 0;
        do_run(0);

        // Reset during DRAIN aborts silently
        send(CMD_RUN, 32'h0);
        for (int t = 0; ; t++) begin
            @(negedge clock);
            if (dp_flush_if) break;
            if (t > 100) begin fail_evt("drain_wait_timeout"); break; end
        end
        @(posedge clock); #1;
        resetGral = 1'b1;
        @(posedge clock); #1;
        resetGral = 1'b0;
        m_ptr = 0; m_pc = 0; m_primed = 0;
        @(negedge clock);
        check_all_zero("drain_reset");
        @(posedge clock); #1;
        do_run(0);

`ifdef RUN_CTRL_WATCHDOG_EN
        for (int k = 0; k < 256; k++) load_word(32'h0000_0000);
        send(CMD_RUN, 32'h0);
        wait_idle();
        chk("wdt_err_set", wdt_err, 1);
        chk("wdt_enable_cycles", en_cnt, WDT);
        chk("wdt_reset_cycles", rs_cnt, 1);
        chk("wdt_flush_cycles", fl_cnt, 0);
        resetGral = 1'b1;
        @(posedge clock); #1;
        resetGral = 1'b0;
        @(negedge clock);
        chk("wdt_err_cleared", wdt_err, 0);
`else
        chk("wdt_err_tied", wdt_err, 0);
`endif

        repeat (3) @(posedge clock);
        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
